// File: rtl/hub75_rx.sv
// HUB75 panel-bus receiver: pixel beats, line latches and OE display intervals.
// Define HUB75_RX_SYNC_EN to add two-flop input synchronizers (latency 4 clk instead of 2).
module hub75_rx #(
  parameter int vpixel_p   = 64,
  parameter int hpixel_p   = 64,
  parameter int segments_p = 2,
  parameter int bpp_p      = 8
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  i_en,
  input  logic                                  i_hub_clk,
  input  logic                                  i_hub_lat,
  input  logic                                  i_hub_oe_n,
  input  logic [$clog2(vpixel_p/segments_p)-1:0] i_hub_addr,
  input  logic [3*segments_p-1:0]               i_hub_rgb,
  output logic                                  o_pix_valid,
  output logic [$clog2(hpixel_p)-1:0]           o_pix_col,
  output logic [3*segments_p-1:0]               o_pix_rgb,
  output logic                                  o_line_valid,
  output logic [$clog2(vpixel_p/segments_p)-1:0] o_line_row,
  output logic [$clog2(hpixel_p):0]             o_line_len,
  output logic                                  o_line_err,
  output logic                                  o_oe_valid,
  output logic [$clog2(vpixel_p/segments_p)-1:0] o_oe_row,
  output logic [2*bpp_p-1:0]                    o_oe_cycles,
  output logic                                  o_oe_sat
);

  localparam int AW = $clog2(vpixel_p/segments_p);
  localparam int CW = $clog2(hpixel_p);
  localparam int LW = CW + 1;
  localparam int DW = 3*segments_p;
  localparam int OW = 2*bpp_p;
  localparam logic [LW-1:0] HPIX = LW'(hpixel_p);
  localparam logic [2:0] CTL_IDLE = 3'b100; // {oe_n, lat, clk} bus-idle levels

  logic [2:0]    ctl_in;
  logic [AW-1:0] addr_in;
  logic [DW-1:0] rgb_in;

`ifdef HUB75_RX_SYNC_EN
  logic [2:0]    ctl_m_q, ctl_y_q;
  logic [AW-1:0] addr_m_q, addr_y_q;
  logic [DW-1:0] rgb_m_q, rgb_y_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctl_m_q  <= CTL_IDLE;
      ctl_y_q  <= CTL_IDLE;
      addr_m_q <= '0;
      addr_y_q <= '0;
      rgb_m_q  <= '0;
      rgb_y_q  <= '0;
    end else begin
      ctl_m_q  <= {i_hub_oe_n, i_hub_lat, i_hub_clk};
      ctl_y_q  <= ctl_m_q;
      addr_m_q <= i_hub_addr;
      addr_y_q <= addr_m_q;
      rgb_m_q  <= i_hub_rgb;
      rgb_y_q  <= rgb_m_q;
    end
  end

  assign ctl_in  = ctl_y_q;
  assign addr_in = addr_y_q;
  assign rgb_in  = rgb_y_q;
`else
  assign ctl_in  = {i_hub_oe_n, i_hub_lat, i_hub_clk};
  assign addr_in = i_hub_addr;
  assign rgb_in  = i_hub_rgb;
`endif

  logic [2:0]    s_ctl_q, p_ctl_q;
  logic [AW-1:0] s_addr_q;
  logic [DW-1:0] s_rgb_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_ctl_q  <= CTL_IDLE;
      p_ctl_q  <= CTL_IDLE;
      s_addr_q <= '0;
      s_rgb_q  <= '0;
    end else begin
      s_ctl_q  <= ctl_in;
      p_ctl_q  <= s_ctl_q;
      s_addr_q <= addr_in;
      s_rgb_q  <= rgb_in;
    end
  end

  logic clk_rise, lat_rise, oe_fall, oe_rise;
  assign clk_rise = s_ctl_q[0] & ~p_ctl_q[0];
  assign lat_rise = s_ctl_q[1] & ~p_ctl_q[1];
  assign oe_fall  = ~s_ctl_q[2] & p_ctl_q[2];
  assign oe_rise  = s_ctl_q[2] & ~p_ctl_q[2];

  logic [LW-1:0] col_q, col_d;
  logic          ovf_q, ovf_d;
  logic          pix_valid_d, line_valid_d, line_err_d;
  logic [CW-1:0] pix_col_d;
  logic [DW-1:0] pix_rgb_d;
  logic [AW-1:0] line_row_d;
  logic [LW-1:0] line_len_d;

  // A shift coinciding with a latch is counted before the latch closes the line.
  always_comb begin
    col_d        = col_q;
    ovf_d        = ovf_q;
    pix_valid_d  = 1'b0;
    pix_col_d    = o_pix_col;
    pix_rgb_d    = o_pix_rgb;
    line_valid_d = 1'b0;
    line_row_d   = o_line_row;
    line_len_d   = o_line_len;
    line_err_d   = o_line_err;
    if (!i_en) begin
      col_d = '0;
      ovf_d = 1'b0;
    end else begin
      if (clk_rise) begin
        if (col_q < HPIX) begin
          pix_valid_d = 1'b1;
          pix_col_d   = col_q[CW-1:0];
          pix_rgb_d   = s_rgb_q;
          col_d       = col_q + LW'(1);
        end else begin
          ovf_d = 1'b1;
        end
      end
      if (lat_rise) begin
        line_valid_d = 1'b1;
        line_row_d   = s_addr_q;
        line_len_d   = col_d;
        line_err_d   = (col_d != HPIX) || ovf_d;
        col_d        = '0;
        ovf_d        = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_q        <= '0;
      ovf_q        <= 1'b0;
      o_pix_valid  <= 1'b0;
      o_pix_col    <= '0;
      o_pix_rgb    <= '0;
      o_line_valid <= 1'b0;
      o_line_row   <= '0;
      o_line_len   <= '0;
      o_line_err   <= 1'b0;
    end else begin
      col_q        <= col_d;
      ovf_q        <= ovf_d;
      o_pix_valid  <= pix_valid_d;
      o_pix_col    <= pix_col_d;
      o_pix_rgb    <= pix_rgb_d;
      o_line_valid <= line_valid_d;
      o_line_row   <= line_row_d;
      o_line_len   <= line_len_d;
      o_line_err   <= line_err_d;
    end
  end

  typedef enum logic [1:0] {IDLE, BLANK, ON} oe_state_e;
  oe_state_e     oe_state_q;
  logic [OW-1:0] oe_cnt_q;
  logic          oe_sat_q;
  logic [AW-1:0] oe_row_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      oe_state_q  <= IDLE;
      oe_cnt_q    <= '0;
      oe_sat_q    <= 1'b0;
      oe_row_q    <= '0;
      o_oe_valid  <= 1'b0;
      o_oe_row    <= '0;
      o_oe_cycles <= '0;
      o_oe_sat    <= 1'b0;
    end else begin
      o_oe_valid <= 1'b0;
      if (!i_en) begin
        oe_state_q <= IDLE;
        oe_cnt_q   <= '0;
        oe_sat_q   <= 1'b0;
      end else begin
        case (oe_state_q)
          IDLE: oe_state_q <= BLANK;
          BLANK: begin
            if (oe_fall) begin
              oe_state_q <= ON;
              oe_row_q   <= s_addr_q;
              oe_cnt_q   <= OW'(1);
              oe_sat_q   <= 1'b0;
            end
          end
          ON: begin
            if (oe_rise) begin
              oe_state_q  <= BLANK;
              o_oe_valid  <= 1'b1;
              o_oe_row    <= oe_row_q;
              o_oe_cycles <= oe_cnt_q;
              o_oe_sat    <= oe_sat_q;
            end else if (&oe_cnt_q) begin
              oe_sat_q <= 1'b1;
            end else begin
              oe_cnt_q <= oe_cnt_q + OW'(1);
            end
          end
          default: oe_state_q <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: doc/hub75_rx.md
HUB75_RX -- requirements
Module: hub75_rx

Interface
REQ-001 SHALL have parameters: vpixel_p, default 64, panel rows; hpixel_p, default 64, panel columns; segments_p, default 2, independently driven panel segments; bpp_p, default 8, colour depth (sets the OE counter width).
REQ-002 SHALL have ports: clk  in  1  system clock; all logic on rising edge.
REQ-003 SHALL have ports: rst  in  1  reset, asynchronous, active-high.
REQ-004 SHALL have ports: i_en  in  1  receiver enable; low holds the block idle.
REQ-005 SHALL have ports: i_hub_clk  in  1  HUB75 shift clock; i_hub_lat  in  1  latch; i_hub_oe_n  in  1  output enable, active-low.
REQ-006 SHALL have ports: i_hub_addr  in  $clog2(vpixel_p/segments_p)  row select; i_hub_rgb  in  3*segments_p  RGB data, {R,G,B} per segment, segment 0 in LSBs.
REQ-007 SHALL have ports: o_pix_valid  out  1  pixel beat strobe; o_pix_col  out  $clog2(hpixel_p)  column index; o_pix_rgb  out  3*segments_p  sampled data.
REQ-008 SHALL have ports: o_line_valid  out  1  latch strobe; o_line_row  out  $clog2(vpixel_p/segments_p); o_line_len  out  $clog2(hpixel_p)+1  shift count; o_line_err  out  1  length mismatch.
REQ-009 SHALL have ports: o_oe_valid  out  1  display-interval strobe; o_oe_row  out  $clog2(vpixel_p/segments_p); o_oe_cycles  out  2*bpp_p  low time in clk cycles; o_oe_sat  out  1  counter saturated.

Function
REQ-010 SHALL register all HUB75 inputs in a sample stage and keep one previous-value copy of clk/lat/oe_n for edge detection; all strobes are single-cycle pulses.
REQ-011 SHALL, on a sampled i_hub_clk rising edge with col_cnt < hpixel_p, pulse o_pix_valid with o_pix_col=col_cnt and o_pix_rgb=data sampled at that edge, then increment col_cnt.
REQ-012 SHALL, on a shift edge with col_cnt == hpixel_p, emit no beat, hold col_cnt, and set an overflow flag.
REQ-013 SHALL, on a sampled i_hub_lat rising edge, pulse o_line_valid with o_line_row=sampled addr and o_line_len=col_cnt, with o_line_err=1 if col_cnt != hpixel_p or overflow is set; then clear col_cnt and overflow.
REQ-014 SHALL, when shift and latch edges coincide, count the shift first: the beat is emitted and included in o_line_len.
REQ-015 SHALL implement OE FSM states IDLE, BLANK, ON: IDLE->BLANK when i_en=1; BLANK->ON on sampled oe_n falling edge (capture row, cycles=1); ON stays while oe_n low (cycles+1 per clk, saturating at all-ones and setting sat); ON->BLANK on oe_n rising edge, pulsing o_oe_valid with captured row, cycles, sat.
REQ-016 SHALL run shift/latch tracking independently of the OE FSM; shifting during ON is legal.
REQ-017 SHALL, when i_en=0, force IDLE, clear col_cnt, overflow, OE counter and sat, and emit no strobes (an interrupted ON interval produces no o_oe_valid).
REQ-018 SHALL hold o_pix_*, o_line_*, o_oe_* data outputs stable between strobes.

Reset
REQ-019 SHALL on rst clear all outputs to 0, FSM to IDLE, counters and flags to 0, and sample/previous registers to bus-idle levels (clk=0, lat=0, oe_n=1), so no false edge follows reset.
REQ-020 SHALL tolerate reset assertion mid-line; the first line after reset starts at column 0.

Configuration
REQ-021 SHALL, with HUB75_RX_SYNC_EN defined, pass all HUB75 inputs through two-flop synchronizers before the sample stage; input-to-strobe latency is 4 clk.
REQ-022 SHALL, without HUB75_RX_SYNC_EN, sample inputs directly in a single register stage; input-to-strobe latency is 2 clk; the source must be synchronous to clk.

Verification
REQ-023 SHALL cover: 64 shift pulses with rgb=col[5:0], then LAT, addr=3 -> 64 beats col 0..63 with matching rgb; o_line_len=64, row=3, err=0.
REQ-024 SHALL cover: 10 shift pulses then LAT -> 10 beats; o_line_len=10, err=1; next line starts at col 0.
REQ-025 SHALL cover: 70 shift pulses then LAT -> 64 beats only; o_line_len=64, err=1.
REQ-026 SHALL cover: oe_n low 37 clk, addr=5, with shifting in parallel -> one o_oe_valid, cycles=37, row=5, sat=0.
REQ-027 SHALL cover: bpp_p=8, oe_n low 70000 clk -> o_oe_valid with cycles=65535, sat=1.
REQ-028 SHALL cover: i_en dropped during ON, then rst pulsed mid-line -> no o_oe_valid; all outputs 0; next line counts from col 0.
